// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial add/subtract, one bit per clock LSB first, with start/busy/done handshake.
// Define SERIAL_ADD_SUB_EN to honour the sub input (two's-complement subtract); otherwise add-only.
module serial_add_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_r, b_r, b_eff;
    logic [CW-1:0]    cnt;
    logic             carry, sub_eff, accept, last, sum, carry_next;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_eff = sub;
    assign b_eff   = sub ? ~b : b;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign sub_eff    = 1'b0;
    assign b_eff      = b;
`endif

    assign accept     = (state != RUN) && start;
    assign last       = cnt == LAST;
    assign sum        = a_r[cnt] ^ b_r[cnt] ^ carry;
    assign carry_next = (a_r[cnt] & b_r[cnt]) | (carry & (a_r[cnt] ^ b_r[cnt]));

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    // Next state and handshake outputs; abort beats the final bit, start beats abort outside RUN.
    always_comb begin
        state_next = (state == RUN) ? (abort ? IDLE : (last ? DONE : RUN))
                                    : (start ? RUN : IDLE);
        busy = state == RUN;
        done = state == DONE;
    end

    // Operand capture and the shared full-adder step, one result bit per clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r    <= '0;
            b_r    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_r    <= a;
            b_r    <= b_eff;
            carry  <= sub_eff;
            cnt    <= '0;
            result <= '0;
        end else if (state == RUN) begin
            if (abort) begin
                result <= '0;
                cout   <= 1'b0;
                ovf    <= 1'b0;
            end else begin
                result[cnt] <= sum;
                carry       <= carry_next;
                cnt         <= cnt + CW'(1);
                if (last) begin
                    cout <= carry_next;
                    ovf  <= carry ^ carry_next;
                end
            end
        end
    end
endmodule
